// File: rtl/core_cbus_bridge.sv
// Uncached bridge: arbitrates one ibus and one dbus request onto a single-beat cbus transaction
// and returns the response to whichever port was granted.
module core_cbus_bridge #(
    parameter bit RR_ARB = 1'b1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [64:0]  ireq,
    output logic [33:0]  iresp,
    input  logic [139:0] dreq,
    output logic [65:0]  dresp,
    output logic [150:0] creq,
    input  logic [65:0]  cresp
);

    localparam logic [2:0] MSIZE4      = 3'b010;
    localparam logic [7:0] MLEN1       = 8'd0;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e      state_q, state_d;
    logic        gnt_d_q, gnt_d_d;            // 1: current transaction belongs to dbus
    logic        last_gnt_d_q, last_gnt_d_d;
    logic [63:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] data_q, data_d;
    logic [63:0] word_q, word_d;

    logic        i_valid, d_valid, take, pick_d;
    logic [63:0] i_addr, d_addr, d_data;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic        c_ready, c_last;
    logic [63:0] c_data;

    assign i_valid  = ireq[64];
    assign i_addr   = ireq[63:0];
    assign d_valid  = dreq[139];
    assign d_addr   = dreq[138:75];
    assign d_size   = dreq[74:72];
    assign d_strobe = dreq[71:64];
    assign d_data   = dreq[63:0];
    assign c_ready  = cresp[65];
    assign c_last   = cresp[64];
    assign c_data   = cresp[63:0];

    // On a tie, round-robin hands the grant to whichever port did not win last time.
    assign pick_d = d_valid && (!i_valid || !RR_ARB || !last_gnt_d_q);
    assign take   = (state_q == StIdle) && (i_valid || d_valid);

    always_comb begin
        state_d      = state_q;
        gnt_d_d      = gnt_d_q;
        last_gnt_d_d = last_gnt_d_q;
        addr_d       = addr_q;
        size_d       = size_q;
        strobe_d     = strobe_q;
        data_d       = data_q;
        word_d       = word_q;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    gnt_d_d      = pick_d;
                    last_gnt_d_d = pick_d;
                    addr_d       = pick_d ? d_addr : i_addr;
                    size_d       = pick_d ? d_size : MSIZE4;
                    strobe_d     = pick_d ? d_strobe : 8'h00;
                    data_d       = pick_d ? d_data : 64'h0;
                    state_d      = StBusy;
                end
            end
            StBusy: begin
                // A ready beat without last is a protocol error and is ignored.
                if (c_ready && c_last) begin
                    word_d  = c_data;
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            gnt_d_q      <= 1'b0;
            last_gnt_d_q <= 1'b0;
            addr_q       <= 64'h0;
            size_q       <= 3'h0;
            strobe_q     <= 8'h0;
            data_q       <= 64'h0;
            word_q       <= 64'h0;
        end else begin
            state_q      <= state_d;
            gnt_d_q      <= gnt_d_d;
            last_gnt_d_q <= last_gnt_d_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            strobe_q     <= strobe_d;
            data_q       <= data_d;
            word_q       <= word_d;
        end
    end

    logic busy, resp;
    assign busy = (state_q == StBusy);
    assign resp = (state_q == StResp);

    assign creq = {busy, |strobe_q, size_q, addr_q, strobe_q, data_q, MLEN1, BURST_FIXED};

    // addr_ok is combinational, so it is gated by reset to keep outputs quiet during reset.
    assign iresp = {resetn && take && !pick_d, resp && !gnt_d_q,
                    addr_q[2] ? word_q[63:32] : word_q[31:0]};
    assign dresp = {resetn && take && pick_d, resp && gnt_d_q, word_q};

endmodule

// File: tb/tb_core_cbus_bridge.sv
// Directed and randomized checks of core_cbus_bridge against a rule-level reference model;
// two instances (round-robin and dbus-priority) share the same stimulus.
module tb_core_cbus_bridge;

    logic         clk, resetn;
    logic [64:0]  ireq;
    logic [139:0] dreq;
    logic [65:0]  cresp;
    logic [33:0]  iresp, iresp0;
    logic [65:0]  dresp, dresp0;
    logic [150:0] creq, creq0;

    int n_pass  = 0;
    int n_total = 0;
    bit last_g  = 1'b0;  // model: 1 = dbus won last arbitration
    bit last_g0 = 1'b0;

    core_cbus_bridge #(.RR_ARB(1'b1)) dut (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp), .dreq(dreq), .dresp(dresp),
        .creq(creq), .cresp(cresp)
    );

    core_cbus_bridge #(.RR_ARB(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .ireq(ireq), .iresp(iresp0), .dreq(dreq), .dresp(dresp0),
        .creq(creq0), .cresp(cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [150:0] obs, input logic [150:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [64:0] mk_ireq(input bit v, input logic [63:0] a);
        return {v, a};
    endfunction

    function automatic logic [139:0] mk_dreq(input bit v, input logic [63:0] a,
                                             input logic [2:0] sz, input logic [7:0] st,
                                             input logic [63:0] d);
        return {v, a, sz, st, d};
    endfunction

    // Arbitration rule: lone requester wins; tie goes to dbus unless round-robin says ibus.
    function automatic bit predict(input bit iv, input bit dv, input bit rr, input bit last);
        if (dv && !iv) return 1'b1;
        if (iv && !dv) return 1'b0;
        return rr ? !last : 1'b1;
    endfunction

    function automatic logic [150:0] exp_creq(input bit is_d);
        logic [63:0] a;
        logic [7:0]  st;
        if (!is_d) begin
            a = ireq[63:0];
            return {1'b1, 1'b0, 3'b010, a, 8'h00, 64'h0, 8'h00, 2'b00};
        end
        a  = dreq[138:75];
        st = dreq[71:64];
        return {1'b1, (st != 8'h00), dreq[74:72], a, st, dreq[63:0], 8'h00, 2'b00};
    endfunction

    function automatic logic [33:0] exp_iresp(input logic [63:0] word);
        logic [63:0] a;
        a = ireq[63:0];
        return {2'b01, a[2] ? word[63:32] : word[31:0]};
    endfunction

    // Called at a negedge in IDLE with requests driven; returns at a negedge in IDLE.
    task automatic do_txn(input int k, input logic [63:0] word, input bit glitch);
        bit gd, gd0;
        logic [150:0] ec, ec0;
        logic [33:0]  ei, ei0;
        gd  = predict(ireq[64], dreq[139], 1'b1, last_g);
        gd0 = predict(ireq[64], dreq[139], 1'b0, last_g0);
        ec  = exp_creq(gd);
        ec0 = exp_creq(gd0);
        ei  = exp_iresp(word);
        #1;
        chk("addr_ok", {iresp[33], dresp[65]}, gd ? 2'b01 : 2'b10);
        chk("addr_ok0", {iresp0[33], dresp0[65]}, gd0 ? 2'b01 : 2'b10);
        @(posedge clk);
        last_g  = gd;
        last_g0 = gd0;
        for (int c = 1; c <= k; c++) begin
            @(negedge clk);
            chk("creq", creq, ec);
            chk("creq0", creq0, ec0);
            chk("silent", {iresp[33:32], dresp[65:64], iresp0[33:32], dresp0[65:64]}, 0);
            if (c == k) cresp = {2'b11, word};
            else if (glitch && c == 1) cresp = {2'b10, ~word};
            else cresp = 66'h0;
            @(posedge clk);
        end
        @(negedge clk);
        cresp = 66'h0;
        chk("resp_creq_valid", {creq[150], creq0[150]}, 2'b00);
        if (gd) chk("dresp", {dresp[65:0], iresp[33:32]}, {2'b01, word, 2'b00});
        else    chk("iresp", {iresp, dresp[65:64]}, {ei, 2'b00});
        if (gd0) chk("dresp0", {dresp0[65:0], iresp0[33:32]}, {2'b01, word, 2'b00});
        else     chk("iresp0", {iresp0, dresp0[65:64]}, {ei, 2'b00});
        @(negedge clk);
        chk("one_data_ok", {iresp[32], dresp[64], iresp0[32], dresp0[64]}, 4'h0);
    endtask

    initial begin
        resetn = 1'b0;
        ireq   = '0;
        dreq   = '0;
        cresp  = '0;
        #1;
        chk("reset_out", {creq, iresp, dresp}, 0);
        chk("reset_out0", {creq0, iresp0, dresp0}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_quiet", {creq[150], iresp[33:32], dresp[65:64]}, 0);

        // dbus read
        dreq = mk_dreq(1'b1, 64'h8000_0010, 3'b011, 8'h00, 64'h0);
        do_txn(2, 64'h1122_3344_5566_7788, 1'b0);
        dreq = '0;
        // ibus upper and lower halves
        ireq = mk_ireq(1'b1, 64'h8000_0004);
        do_txn(1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        ireq = mk_ireq(1'b1, 64'h8000_0000);
        do_txn(3, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0);
        ireq = '0;
        // dbus write
        dreq = mk_dreq(1'b1, 64'h8000_0100, 3'b010, 8'h0F, 64'hDEAD_BEEF);
        do_txn(2, 64'h0, 1'b0);
        // ready without last is ignored
        dreq = mk_dreq(1'b1, 64'h8000_0200, 3'b011, 8'h00, 64'h0);
        do_txn(3, 64'h0123_4567_89AB_CDEF, 1'b1);
        dreq = '0;

        // reset while busy
        dreq = mk_dreq(1'b1, 64'h8000_0300, 3'b011, 8'h00, 64'h0);
        @(posedge clk);
        @(negedge clk);
        chk("busy_valid", creq[150], 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_busy_out", {creq, iresp, dresp}, 0);
        chk("rst_busy_out0", {creq0, iresp0, dresp0}, 0);
        dreq = '0;
        @(negedge clk);
        resetn  = 1'b1;
        last_g  = 1'b0;
        last_g0 = 1'b0;
        cresp   = {2'b11, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale", {creq[150], iresp[33:32], dresp[65:64], iresp0[32], dresp0[64]}, 0);
        end
        cresp = '0;

        // ties: RR gives D,I,D,I; priority gives D every time
        for (int t = 0; t < 4; t++) begin
            ireq = mk_ireq(1'b1, 64'h8000_1000 + 64'(t * 4));
            dreq = mk_dreq(1'b1, 64'h8000_2000 + 64'(t * 8), 3'b011, 8'h00, 64'h0);
            chk("tie_grant_rr", {31'h0, last_g}, 32'(t % 2));
            do_txn(1 + t % 3, {$urandom, $urandom}, 1'b0);
        end

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int v, kk;
            v    = $urandom_range(1, 3);
            kk   = $urandom_range(1, 4);
            ireq = mk_ireq(v[0], {$urandom, $urandom});
            dreq = mk_dreq(v[1], {$urandom, $urandom}, 3'($urandom_range(0, 3)),
                           ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00,
                           {$urandom, $urandom});
            do_txn(kk, {$urandom, $urandom}, (kk > 1) && ($urandom_range(0, 1) != 0));
        end
        ireq = '0;
        dreq = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
